// File: rtl/id_checker_multi_if.sv
// ID beat stream and per-ID result bundle for id_checker_multi.
// master drives ID beats (stimulus side); slave is the checker.
interface id_checker_multi_if #(
   parameter int CNT_W = 8
);
   logic             in_valid;
   logic             in_mode;
   logic [6:0]       in_id;
   logic             out_valid;
   logic             out_legal_id;
   logic             out_err;
   logic [CNT_W-1:0] legal_cnt;

   modport master (
      output in_valid, in_mode, in_id,
      input  out_valid, out_legal_id, out_err, legal_cnt
   );

   modport slave (
      input  in_valid, in_mode, in_id,
      output out_valid, out_legal_id, out_err, legal_cnt
   );
endinterface

// File: rtl/id_checker_multi.sv
// Multi-beat decimal ID checker: weighted mod-10 or Luhn check digit, a
// mod-10 running sum updated per beat, a 1-cycle result pulse and a saturating legal count.
module id_checker_multi #(
   parameter int N_GROUPS = 5,
   parameter int CNT_W    = 8
) (
   input logic               clk,
   input logic               rst_n,
   id_checker_multi_if.slave bus
);
   typedef enum logic {IDLE, ACC} state_t;

   localparam logic [2:0] LAST = 3'(N_GROUPS - 1);
   localparam logic [4:0] TOPW = 5'(2 * N_GROUPS - 1);

   state_t           state_q, state_d;
   logic [2:0]       cnt_q, cnt_d;
   logic [3:0]       sum_q, sum_d;
   logic             mode_q, mode_d;
   logic             err_q, err_d;
   logic             valid_q, valid_d;
   logic             legal_q, legal_d;
   logic             oerr_q, oerr_d;
   logic [CNT_W-1:0] lcnt_q, lcnt_d;

   logic       is_last, mode_eff, range_err, bad;
   logic [2:0] beat;
   logic [3:0] t, u, sum_nx, chk;
   logic [4:0] wt, wu, t2;
   logic [8:0] tterm, uterm, acc;

   // Beat datapath: weights follow from the beat index; the last beat's units digit is the check digit.
   always_comb begin
      beat      = (state_q == IDLE) ? 3'd0 : cnt_q;
      is_last   = (beat == LAST);
      mode_eff  = (state_q == IDLE) ? bus.in_mode : mode_q;
      range_err = (bus.in_id > 7'd99);
      t         = 4'(bus.in_id / 7'd10);
      u         = 4'(bus.in_id % 7'd10);
      t2        = {t, 1'b0};
      wt        = (beat == 3'd0 || is_last) ? 5'd1 : TOPW - 5'({beat, 1'b0});
      wu        = TOPW - 5'd1 - 5'({beat, 1'b0});
      if (mode_eff) begin
         tterm = (t2 > 5'd9) ? 9'(t2 - 5'd9) : 9'(t2);
         uterm = 9'(u);
      end else begin
         tterm = 9'(t) * 9'(wt);
         uterm = 9'(u) * 9'(wu);
      end
      if (is_last) uterm = '0;
      acc    = 9'(sum_q) + tterm + uterm;
      sum_nx = 4'(acc % 9'd10);
      chk    = 4'((5'd10 - 5'(sum_nx)) % 5'd10);
      bad    = err_q | range_err;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      mode_d  = mode_q;
      err_d   = err_q;
      valid_d = 1'b0;
      legal_d = 1'b0;
      oerr_d  = 1'b0;
      lcnt_d  = lcnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               mode_d  = bus.in_mode;
               err_d   = range_err;
               sum_d   = sum_nx;
               cnt_d   = 3'd1;
               state_d = ACC;
            end
         end
         ACC: begin
            if (!bus.in_valid || is_last) begin
               valid_d = 1'b1;
               oerr_d  = !bus.in_valid || bad;
               legal_d = bus.in_valid && !bad && (u == chk);
               if (legal_d && lcnt_q != '1) lcnt_d = lcnt_q + 1'b1;
               state_d = IDLE;
               cnt_d   = '0;
               sum_d   = '0;
               err_d   = 1'b0;
            end else begin
               cnt_d = cnt_q + 3'd1;
               sum_d = sum_nx;
               err_d = bad;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         sum_q   <= '0;
         mode_q  <= 1'b0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         legal_q <= 1'b0;
         oerr_q  <= 1'b0;
         lcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         mode_q  <= mode_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         legal_q <= legal_d;
         oerr_q  <= oerr_d;
         lcnt_q  <= lcnt_d;
      end
   end

   assign bus.out_valid    = valid_q;
   assign bus.out_legal_id = legal_q;
   assign bus.out_err      = oerr_q;
   assign bus.legal_cnt    = lcnt_q;
endmodule

// File: tb/tb_id_checker_multi.sv
// Bench for id_checker_multi: three instances (N=5/CNT=8, N=5/CNT=2, N=2/CNT=8)
// checked every cycle against a digit-level reference model built from whole IDs.
module tb_id_checker_multi;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   id_checker_multi_if #(.CNT_W(8)) ifa ();
   id_checker_multi_if #(.CNT_W(2)) ifb ();
   id_checker_multi_if #(.CNT_W(8)) ifc ();

   id_checker_multi #(.N_GROUPS(5), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
   id_checker_multi #(.N_GROUPS(5), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
   id_checker_multi #(.N_GROUPS(2), .CNT_W(8)) dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

   int checks = 0;
   int errors = 0;

   // model state: index 0 = five-group instances, 1 = two-group instance
   int qs[2][$];
   bit mlat[2];
   int nb[2] = '{5, 2};
   int cnt_a = 0, cnt_b = 0, cnt_c = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Check digit from the full digit string; the last beat's units digit is ignored.
   function automatic int calc_check(int n, bit mode, int b[$]);
      int d[16];
      int s = 0;
      int x;
      for (int k = 0; k < n; k++) begin
         d[2*k]   = b[k] / 10;
         d[2*k+1] = b[k] % 10;
      end
      if (!mode) begin
         s = d[0];
         for (int i = 1; i <= 2*n-2; i++) s += d[i] * (2*n-1-i);
      end else begin
         for (int j = 0; j <= 2*n-2; j++) begin
            x = d[2*n-2-j];
            if (j % 2 == 0) begin
               x = 2 * x;
               if (x > 9) x -= 9;
            end
            s += x;
         end
      end
      return (10 - s % 10) % 10;
   endfunction

   task automatic model_step(int k, bit v, bit m, int id, output bit ov, output bit ol, output bit oe);
      bit rng = 1'b0;
      ov = 1'b0; ol = 1'b0; oe = 1'b0;
      if (v) begin
         if (qs[k].size() == 0) mlat[k] = m;
         qs[k].push_back(id);
         if (qs[k].size() == nb[k]) begin
            foreach (qs[k][i]) if (qs[k][i] > 99) rng = 1'b1;
            ov = 1'b1;
            oe = rng;
            ol = !rng && (calc_check(nb[k], mlat[k], qs[k]) == qs[k][nb[k]-1] % 10);
            qs[k].delete();
         end
      end else if (qs[k].size() != 0) begin
         ov = 1'b1;
         oe = 1'b1;
         qs[k].delete();
      end
   endtask

   task automatic tick();
      bit v5, l5, e5, v2, l2, e2;
      @(posedge clk); #1;
      model_step(0, ifa.in_valid, ifa.in_mode, int'(ifa.in_id), v5, l5, e5);
      model_step(1, ifc.in_valid, ifc.in_mode, int'(ifc.in_id), v2, l2, e2);
      if (l5) begin
         if (cnt_a < 255) cnt_a++;
         if (cnt_b < 3) cnt_b++;
      end
      if (l2 && cnt_c < 255) cnt_c++;
      chk("a_valid", 32'(ifa.out_valid), 32'(v5));
      chk("a_legal", 32'(ifa.out_legal_id), 32'(l5));
      chk("a_err", 32'(ifa.out_err), 32'(e5));
      chk("a_cnt", 32'(ifa.legal_cnt), cnt_a);
      chk("b_valid", 32'(ifb.out_valid), 32'(v5));
      chk("b_legal", 32'(ifb.out_legal_id), 32'(l5));
      chk("b_err", 32'(ifb.out_err), 32'(e5));
      chk("b_cnt", 32'(ifb.legal_cnt), cnt_b);
      chk("c_valid", 32'(ifc.out_valid), 32'(v2));
      chk("c_legal", 32'(ifc.out_legal_id), 32'(l2));
      chk("c_err", 32'(ifc.out_err), 32'(e2));
      chk("c_cnt", 32'(ifc.legal_cnt), cnt_c);
   endtask

   task automatic set5(bit v, bit m, int id);
      ifa.in_valid = v; ifa.in_mode = m; ifa.in_id = 7'(id);
      ifb.in_valid = v; ifb.in_mode = m; ifb.in_id = 7'(id);
   endtask

   task automatic set2(bit v, bit m, int id);
      ifc.in_valid = v; ifc.in_mode = m; ifc.in_id = 7'(id);
   endtask

   task automatic drv5(bit v, bit m, int id);
      set5(v, m, id);
      set2(1'b0, 1'b0, 0);
      tick();
   endtask

   task automatic drv2(bit v, bit m, int id);
      set5(1'b0, 1'b0, 0);
      set2(v, m, id);
      tick();
   endtask

   // Beats 1..4 carry a random in_mode, which must be ignored.
   task automatic id5(bit m, int b0, int b1, int b2, int b3, int b4);
      drv5(1'b1, m, b0);
      drv5(1'b1, 1'($urandom), b1);
      drv5(1'b1, 1'($urandom), b2);
      drv5(1'b1, 1'($urandom), b3);
      drv5(1'b1, 1'($urandom), b4);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      qs[0].delete(); qs[1].delete();
      cnt_a = 0; cnt_b = 0; cnt_c = 0;
      chk("rst_a_valid", 32'(ifa.out_valid), 0);
      chk("rst_a_legal", 32'(ifa.out_legal_id), 0);
      chk("rst_a_err", 32'(ifa.out_err), 0);
      chk("rst_a_cnt", 32'(ifa.legal_cnt), 0);
      chk("rst_b_valid", 32'(ifb.out_valid), 0);
      chk("rst_b_cnt", 32'(ifb.legal_cnt), 0);
      chk("rst_c_valid", 32'(ifc.out_valid), 0);
      chk("rst_c_cnt", 32'(ifc.legal_cnt), 0);
   endtask

   initial begin
      int base;
      int tmp[$];
      int id, t;
      bit v, m;

      set5(1'b0, 1'b0, 0);
      set2(1'b0, 1'b0, 0);
      do_reset();
      drv5(1'b0, 1'b0, 0);

      // weighted legal, then wrong check digit
      id5(1'b0, 12, 34, 56, 78, 93);
      chk("m0_legal_valid", 32'(ifa.out_valid), 1);
      chk("m0_legal", 32'(ifa.out_legal_id), 1);
      chk("m0_legal_cnt", 32'(ifa.legal_cnt), 1);
      id5(1'b0, 12, 34, 56, 78, 94);
      chk("m0_illegal", 32'(ifa.out_legal_id), 0);
      chk("m0_illegal_cnt", 32'(ifa.legal_cnt), 1);

      // Luhn legal, and the same digits in weighted mode
      id5(1'b1, 12, 34, 56, 78, 97);
      chk("luhn_legal", 32'(ifa.out_legal_id), 1);
      id5(1'b0, 12, 34, 56, 78, 97);
      chk("luhn_as_m0", 32'(ifa.out_legal_id), 0);
      drv5(1'b0, 1'b0, 0);

      // back-to-back IDs with in_valid held high
      base = cnt_a;
      for (int i = 0; i < 10; i++) begin
         drv5(1'b1, 1'b0, (i % 5 == 0) ? 12 : (i % 5 == 1) ? 34 : (i % 5 == 2) ? 56 : (i % 5 == 3) ? 78 : 93);
         chk("b2b_valid", 32'(ifa.out_valid), 32'(i == 4 || i == 9));
      end
      chk("b2b_cnt", 32'(ifa.legal_cnt), 32'(base + 2));
      drv5(1'b0, 1'b0, 0);

      // abort, then a full legal ID
      drv5(1'b1, 1'b0, 12);
      drv5(1'b1, 1'b0, 34);
      drv5(1'b0, 1'b0, 0);
      chk("abort_valid", 32'(ifa.out_valid), 1);
      chk("abort_err", 32'(ifa.out_err), 1);
      chk("abort_legal", 32'(ifa.out_legal_id), 0);
      id5(1'b0, 12, 34, 56, 78, 93);
      chk("after_abort_legal", 32'(ifa.out_legal_id), 1);

      // range error
      base = cnt_a;
      id5(1'b0, 12, 105, 56, 78, 93);
      chk("range_err", 32'(ifa.out_err), 1);
      chk("range_legal", 32'(ifa.out_legal_id), 0);
      chk("range_cnt", 32'(ifa.legal_cnt), base);

      // saturation of the 2-bit counter, then reset mid-ID
      for (int i = 0; i < 4; i++) id5(1'b0, 12, 34, 56, 78, 93);
      chk("sat_cnt", 32'(ifb.legal_cnt), 3);
      drv5(1'b1, 1'b0, 12);
      drv5(1'b1, 1'b0, 34);
      set5(1'b1, 1'b0, 56);
      do_reset();
      drv5(1'b0, 1'b0, 0);
      chk("post_rst_no_pulse", 32'(ifa.out_valid), 0);
      id5(1'b0, 12, 34, 56, 78, 93);
      chk("post_rst_legal", 32'(ifb.out_legal_id), 1);
      chk("post_rst_cnt", 32'(ifb.legal_cnt), 1);

      // minimum length
      drv2(1'b1, 1'b0, 12);
      drv2(1'b1, 1'b0, 31);
      chk("n2_illegal_valid", 32'(ifc.out_valid), 1);
      chk("n2_illegal", 32'(ifc.out_legal_id), 0);
      drv2(1'b1, 1'b0, 12);
      drv2(1'b1, 1'b0, 32);
      chk("n2_legal", 32'(ifc.out_legal_id), 1);

      // random streams on both lengths; half of completing beats forced legal
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < 2; k++) begin
            v = ($urandom_range(0, 9) != 0);
            m = 1'($urandom);
            id = ($urandom_range(0, 15) == 0) ? int'($urandom_range(100, 127)) : int'($urandom_range(0, 99));
            if (v && qs[k].size() == nb[k] - 1 && $urandom_range(0, 1) == 1) begin
               t = $urandom_range(0, 9);
               tmp = qs[k];
               tmp.push_back(t * 10);
               id = t * 10 + calc_check(nb[k], mlat[k], tmp);
            end
            if (k == 0) set5(v, m, id);
            else set2(v, m, id);
         end
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
